// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, the glyph table and
// encode/decode/classify helpers used by both the transmit and receive sides.
package seg7_pkg;

  // Segment bit positions inside a 7-bit pattern (active-high).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Glyph table, index = hex value. Written MSB-first, so entry 0 (7'h3F) is last.
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Result of a table lookup on a received pattern.
  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } seg7_dec_t;

  // Coarse classification of an accepted pattern.
  typedef enum logic [1:0] {
    SEG7_CLS_LEGAL   = 2'd0,
    SEG7_CLS_BLANK   = 2'd1,
    SEG7_CLS_ILLEGAL = 2'd2
  } seg7_cls_e;

  // Hex value to segment pattern.
  function automatic logic [6:0] seg7_encode(input logic [3:0] hex);
    return SEG7_GLYPHS[hex];
  endfunction

  // Segment pattern to {legal, value}; value is 0 when the pattern is not a glyph.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t res;
    logic [4:0] idx;
    res.legal = 1'b0;
    res.value = 4'h0;
    for (int i = 0; i < 16; i++) begin
      idx = 5'(i);
      if (SEG7_GLYPHS[idx[3:0]] == pattern) begin
        res.legal = 1'b1;
        res.value = idx[3:0];
      end else begin
        res.legal = res.legal;
      end
    end
    return res;
  endfunction

  // Classify a pattern as a legal glyph, blank frame or illegal glyph.
  function automatic seg7_cls_e seg7_classify(input logic [6:0] pattern);
    seg7_dec_t dec;
    dec = seg7_decode(pattern);
    if (pattern == SEG_BLANK) begin
      return SEG7_CLS_BLANK;
    end else if (dec.legal) begin
      return SEG7_CLS_LEGAL;
    end else begin
      return SEG7_CLS_ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/seg7_debounce.sv
// Two-flop synchronizer plus stability counter for the 7-bit pad pattern.
// A pattern is accepted once it has been seen unchanged for STABLE_CYCLES
// consecutive synchronized cycles and differs from the last accepted one.
// stable_pattern holds the accepted pattern; stable_new strobes for one cycle
// on the edge after an accept has been registered.
module seg7_debounce
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [6:0] stable_pattern,
  output logic       stable_new
);

  // Counter saturates at STABLE_CYCLES-1; legal range keeps this within 8 bits.
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] s1_r;
  logic [6:0] s2_r;
  logic [6:0] cand_r;
  logic [6:0] acc_r;
  logic [7:0] stab_cnt_r;
  logic       new_r;

  logic [6:0] cand_nxt_s;
  logic [6:0] acc_nxt_s;
  logic [7:0] stab_nxt_s;
  logic       new_nxt_s;
  logic       accept_s;

  // Accept when the candidate has been stable long enough and is a real change.
  always_comb begin
    accept_s = (stab_cnt_r == STAB_LAST) && (s2_r == cand_r) && (cand_r != acc_r);
  end

  // Candidate tracking, stability counting and accept bookkeeping.
  always_comb begin
    cand_nxt_s = cand_r;
    stab_nxt_s = stab_cnt_r;
    acc_nxt_s  = acc_r;
    new_nxt_s  = 1'b0;

    if (s2_r != cand_r) begin
      cand_nxt_s = s2_r;
      stab_nxt_s = 8'd0;
    end else if (stab_cnt_r < STAB_LAST) begin
      stab_nxt_s = stab_cnt_r + 8'd1;
    end else begin
      stab_nxt_s = stab_cnt_r;
    end

    if (accept_s) begin
      acc_nxt_s = cand_r;
      new_nxt_s = 1'b1;
    end else begin
      acc_nxt_s = acc_r;
      new_nxt_s = 1'b0;
    end
  end

  // Synchronizer chain and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= 7'h00;
      s2_r       <= 7'h00;
      cand_r     <= 7'h00;
      acc_r      <= SEG_BLANK;
      stab_cnt_r <= 8'd0;
      new_r      <= 1'b0;
    end else begin
      s1_r       <= seg_in;
      s2_r       <= s1_r;
      cand_r     <= cand_nxt_s;
      acc_r      <= acc_nxt_s;
      stab_cnt_r <= stab_nxt_s;
      new_r      <= new_nxt_s;
    end
  end

  assign stable_pattern = acc_r;
  assign stable_new     = new_r;

endmodule

// File: rtl/seg7_decoder_rx.sv
// Receive side of the 7-segment link: debounces the pad pattern, decodes
// accepted patterns back to hex and reports new values, blank frames and
// illegal glyphs. Also counts every accepted pattern change.
module seg7_decoder_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       value_out,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] change_count
);

  logic [6:0]       stable_pattern_s;
  logic             stable_new_s;

  logic [3:0]       value_r;
  logic             valid_r;
  logic             blank_r;
  logic             err_r;
  logic             sticky_r;
  logic [CNT_W-1:0] cnt_r;

  seg7_dec_t        dec_s;
  seg7_cls_e        cls_s;
  logic [3:0]       value_nxt_s;
  logic             valid_nxt_s;
  logic             blank_nxt_s;
  logic             err_nxt_s;
  logic             sticky_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  seg7_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk            (clk),
    .rst            (rst),
    .seg_in         (seg_in),
    .stable_pattern (stable_pattern_s),
    .stable_new     (stable_new_s)
  );

  // Decode the accepted pattern and work out the next flag/value/counter state.
  always_comb begin
    dec_s        = seg7_decode(stable_pattern_s);
    cls_s        = seg7_classify(stable_pattern_s);
    value_nxt_s  = value_r;
    valid_nxt_s  = 1'b0;
    blank_nxt_s  = blank_r;
    err_nxt_s    = 1'b0;
    cnt_nxt_s    = cnt_r;

    if (stable_new_s) begin
      // Counter wraps silently at 2^CNT_W.
      cnt_nxt_s = cnt_r + CNT_W'(1);
      case (cls_s)
        SEG7_CLS_LEGAL: begin
          value_nxt_s = dec_s.value;
          valid_nxt_s = 1'b1;
          blank_nxt_s = 1'b0;
        end
        SEG7_CLS_BLANK: begin
          blank_nxt_s = 1'b1;
        end
        SEG7_CLS_ILLEGAL: begin
          blank_nxt_s = 1'b0;
          err_nxt_s   = 1'b1;
        end
        default: begin
          // Unreachable encoding: treat as an illegal glyph so it is never silent.
          blank_nxt_s = 1'b0;
          err_nxt_s   = 1'b1;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end

    // A new error outranks a simultaneous clear.
    if (err_nxt_s) begin
      sticky_nxt_s = 1'b1;
    end else if (clr_err) begin
      sticky_nxt_s = 1'b0;
    end else begin
      sticky_nxt_s = sticky_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r  <= 4'h0;
      valid_r  <= 1'b0;
      blank_r  <= 1'b1;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      value_r  <= value_nxt_s;
      valid_r  <= valid_nxt_s;
      blank_r  <= blank_nxt_s;
      err_r    <= err_nxt_s;
      sticky_r <= sticky_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  assign value_out    = value_r;
  assign valid        = valid_r;
  assign blank        = blank_r;
  assign err          = err_r;
  assign err_sticky   = sticky_r;
  assign change_count = cnt_r;

endmodule
